// File: rtl/iter_pkg.sv
// Shared types and helpers for the iterative pixel writer.
package iter_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} wr_state_t;

  // Linear framebuffer address; callers truncate to their address width.
  function automatic logic [31:0] addr_of(input logic [31:0] x,
                                          input logic [31:0] y,
                                          input logic [31:0] stride);
    return y * stride + x;
  endfunction

endpackage

// File: rtl/iter_fifo.sv
// Synchronous FIFO with async active-low reset; push on a full FIFO is
// accepted only when a pop frees the slot in the same cycle.
module iter_fifo #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTRW = $clog2(DEPTH);
  localparam logic [PTRW:0] FULL_CNT = (PTRW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTRW-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [PTRW:0]    count_reg;
  logic             wr_en, rd_en;

  assign full  = (count_reg == FULL_CNT);
  assign empty = (count_reg == '0);
  assign count = count_reg;
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);
  assign pop_data = mem[rd_ptr_reg];

  // Storage carries no reset so it can map onto distributed RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + PTRW'(1);
      if (rd_en) rd_ptr_reg <= rd_ptr_reg + PTRW'(1);
      case ({wr_en, rd_en})
        2'b10:   count_reg <= count_reg + (PTRW + 1)'(1);
        2'b01:   count_reg <= count_reg - (PTRW + 1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/iter_pixel_writer.sv
// Buffers iterator pixels and issues framebuffer writes under valid/ready.
// Optional ITER_PIXEL_WRITER_CLIP_EN drops off-screen pixels at enqueue.
module iter_pixel_writer
  import iter_pkg::*;
#(
  parameter int CORDW = 10,
  parameter int COLRW = 4,
  parameter int H_RES = 640,
  parameter int V_RES = 480,
  parameter int ADDRW = 19,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [COLRW-1:0] colour,
  input  logic [CORDW-1:0] x,
  input  logic [CORDW-1:0] y,
  input  logic             drawing,
  input  logic             src_done,
  output logic             oe,
  output logic             mem_we,
  output logic [ADDRW-1:0] mem_addr,
  output logic [COLRW-1:0] mem_data,
  input  logic             mem_ready,
  output logic             busy,
  output logic             done,
  output logic             overflow
);

  localparam int CNTW = $clog2(DEPTH) + 1;

  if ((64'(1) << ADDRW) < 64'(H_RES) * 64'(V_RES)) begin : g_addrw_check
    $error("iter_pixel_writer: ADDRW too small for H_RES*V_RES");
  end

  wr_state_t          state_reg, state_next;
  logic               done_reg, done_next;
  logic [COLRW-1:0]   colour_reg;
  logic               overflow_reg;
  logic               mem_we_reg;
  logic [ADDRW-1:0]   mem_addr_reg;
  logic [COLRW-1:0]   mem_data_reg;

  logic [2*CORDW-1:0] pop_data;
  logic [CORDW-1:0]   pop_x, pop_y;
  logic               fifo_full, fifo_empty;
  logic [CNTW-1:0]    fifo_count;
  logic               clip, accept, push, out_load, ovf_set;

`ifdef ITER_PIXEL_WRITER_CLIP_EN
  assign clip = (32'(x) >= H_RES) || (32'(y) >= V_RES);
`else
  assign clip = 1'b0;
`endif

  assign out_load = (!mem_we_reg || mem_ready) && !fifo_empty;
  assign accept   = drawing && (state_reg == RUN) && !clip;
  assign push     = accept && (!fifo_full || out_load);
  assign ovf_set  = accept && fifo_full && !out_load;

  iter_fifo #(
    .WIDTH(2 * CORDW),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ({y, x}),
    .pop       (out_load),
    .pop_data  (pop_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign pop_x = pop_data[CORDW-1:0];
  assign pop_y = pop_data[2*CORDW-1:CORDW];

  always_comb begin
    state_next = state_reg;
    done_next  = 1'b0;
    case (state_reg)
      IDLE:  if (start) state_next = RUN;
      RUN:   if (src_done) state_next = DRAIN;
      DRAIN: begin
        // Finished only once the last write has been accepted.
        if (fifo_empty && !mem_we_reg) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      done_reg     <= 1'b0;
      colour_reg   <= '0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      done_reg  <= done_next;
      if (state_reg == IDLE && start) begin
        colour_reg   <= colour;
        overflow_reg <= 1'b0;
      end else if (ovf_set) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  // Output register: holds address/data steady while the memory stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_we_reg   <= 1'b0;
      mem_addr_reg <= '0;
      mem_data_reg <= '0;
    end else if (out_load) begin
      mem_we_reg   <= 1'b1;
      mem_addr_reg <= ADDRW'(addr_of(32'(pop_x), 32'(pop_y), 32'(H_RES)));
      mem_data_reg <= colour_reg;
    end else if (mem_ready) begin
      mem_we_reg   <= 1'b0;
    end
  end

  // One free slot of slack covers the iterator's one-cycle reaction to oe.
  assign oe       = (state_reg == RUN) && (32'(fifo_count) <= DEPTH - 2);
  assign busy     = (state_reg != IDLE);
  assign done     = done_reg;
  assign overflow = overflow_reg;
  assign mem_we   = mem_we_reg;
  assign mem_addr = mem_addr_reg;
  assign mem_data = mem_data_reg;

endmodule

// File: tb/tb_iter_pixel_writer.sv
// Directed bench for iter_pixel_writer; expectations are hand-computed.
module tb_iter_pixel_writer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  colour = '0;
  logic [9:0]  x = '0;
  logic [9:0]  y = '0;
  logic        drawing = 1'b0;
  logic        src_done = 1'b0;
  logic        mem_ready = 1'b0;
  logic        oe, mem_we, busy, done, overflow;
  logic [18:0] mem_addr;
  logic [3:0]  mem_data;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];

`ifdef ITER_PIXEL_WRITER_CLIP_EN
  localparam int CLIP_WRITES = 0;
`else
  localparam int CLIP_WRITES = 1;
`endif

  always #5 clk = ~clk;

  iter_pixel_writer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .colour    (colour),
    .x         (x),
    .y         (y),
    .drawing   (drawing),
    .src_done  (src_done),
    .oe        (oe),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .mem_ready (mem_ready),
    .busy      (busy),
    .done      (done),
    .overflow  (overflow)
  );

  always @(posedge clk) begin
    if (mem_we && mem_ready) begin
      wr_addr_q.push_back(32'(mem_addr));
      wr_data_q.push_back(32'(mem_data));
    end
    if (done) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_log();
    wr_addr_q.delete();
    wr_data_q.delete();
    done_cnt = 0;
  endtask

  task automatic start_frame(input logic [3:0] c);
    colour = c;
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  task automatic end_frame();
    src_done = 1'b1;
    tick();
    src_done = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 60) begin
      tick();
      n++;
    end
    check({tag, "_done_seen"}, 32'(done), 1);
    check({tag, "_busy_low"}, 32'(busy), 0);
    tick();
    check({tag, "_done_width"}, 32'(done), 0);
  endtask

  initial begin
    repeat (2) tick();
    check("rst_oe", 32'(oe), 0);
    check("rst_mem_we", 32'(mem_we), 0);
    check("rst_addr", 32'(mem_addr), 0);
    check("rst_data", 32'(mem_data), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_ovf", 32'(overflow), 0);
    rst_n = 1'b1;
    tick();

    // Single pixel
    clear_log();
    mem_ready = 1'b1;
    start_frame(4'hA);
    check("t1_busy", 32'(busy), 1);
    check("t1_oe", 32'(oe), 1);
    x = 10'd3; y = 10'd2; drawing = 1'b1;
    tick();
    drawing = 1'b0;
    end_frame();
    wait_done("t1");
    check("t1_nwr", 32'(wr_addr_q.size()), 1);
    if (wr_addr_q.size() == 1) begin
      check("t1_addr", wr_addr_q[0], 1283);
      check("t1_data", wr_data_q[0], 32'hA);
    end
    check("t1_done_cnt", 32'(done_cnt), 1);

    // Eight-pixel burst against a stalled memory
    clear_log();
    mem_ready = 1'b0;
    start_frame(4'h5);
    for (int i = 0; i < 8; i++) begin
      x = 10'(10 + i); y = 10'd1; drawing = 1'b1;
      tick();
      if (i == 6) check("t2_oe_cnt6", 32'(oe), 1);
      if (i == 7) check("t2_oe_cnt7", 32'(oe), 0);
    end
    drawing = 1'b0;
    check("t2_ovf", 32'(overflow), 0);
    check("t2_we_held", 32'(mem_we), 1);
    check("t2_addr_held", 32'(mem_addr), 650);
    end_frame();
    check("t2_oe_drain", 32'(oe), 0);
    mem_ready = 1'b1;
    wait_done("t2");
    check("t2_nwr", 32'(wr_addr_q.size()), 8);
    if (wr_addr_q.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        check($sformatf("t2_addr%0d", i), wr_addr_q[i], 32'(650 + i));
        check($sformatf("t2_data%0d", i), wr_data_q[i], 32'h5);
      end
    end

    // src_done coincident with the last pixel
    clear_log();
    start_frame(4'hC);
    x = 10'd0; y = 10'd0; drawing = 1'b1;
    tick();
    x = 10'd1; src_done = 1'b1;
    tick();
    drawing = 1'b0; src_done = 1'b0;
    wait_done("t3");
    check("t3_nwr", 32'(wr_addr_q.size()), 2);
    if (wr_addr_q.size() == 2) begin
      check("t3_addr0", wr_addr_q[0], 0);
      check("t3_addr1", wr_addr_q[1], 1);
      check("t3_data1", wr_data_q[1], 32'hC);
    end

    // Overflow: drawing into a full FIFO
    clear_log();
    mem_ready = 1'b0;
    start_frame(4'h3);
    for (int i = 0; i < 10; i++) begin
      x = 10'(i); y = 10'd5; drawing = 1'b1;
      tick();
      if (i == 8) check("t4_ovf_full", 32'(overflow), 0);
      if (i == 9) check("t4_ovf_set", 32'(overflow), 1);
    end
    drawing = 1'b0;
    repeat (2) tick();
    check("t4_ovf_sticky", 32'(overflow), 1);
    end_frame();
    mem_ready = 1'b1;
    wait_done("t4");
    check("t4_ovf_after_done", 32'(overflow), 1);
    check("t4_nwr", 32'(wr_addr_q.size()), 9);
    if (wr_addr_q.size() == 9) begin
      check("t4_addr_first", wr_addr_q[0], 3200);
      check("t4_addr_last", wr_addr_q[8], 3208);
    end
    clear_log();
    start_frame(4'h3);
    check("t4_ovf_cleared", 32'(overflow), 0);
    end_frame();
    wait_done("t4b");
    check("t4b_nwr", 32'(wr_addr_q.size()), 0);

    // Off-screen pixel
    clear_log();
    start_frame(4'h7);
    x = 10'd640; y = 10'd0; drawing = 1'b1;
    tick();
    drawing = 1'b0;
    end_frame();
    wait_done("t5");
    check("t5_nwr", 32'(wr_addr_q.size()), 32'(CLIP_WRITES));
    if (CLIP_WRITES == 1 && wr_addr_q.size() == 1)
      check("t5_addr", wr_addr_q[0], 640);

    // Reset in the middle of DRAIN with a write pending
    clear_log();
    mem_ready = 1'b0;
    start_frame(4'h9);
    x = 10'd4; y = 10'd0; drawing = 1'b1;
    tick();
    drawing = 1'b0;
    end_frame();
    tick();
    check("t6_we_pre", 32'(mem_we), 1);
    check("t6_busy_pre", 32'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_we_rst", 32'(mem_we), 0);
    check("t6_busy_rst", 32'(busy), 0);
    check("t6_oe_rst", 32'(oe), 0);
    check("t6_addr_rst", 32'(mem_addr), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    mem_ready = 1'b1;
    repeat (5) tick();
    check("t6_nwr", 32'(wr_addr_q.size()), 0);
    check("t6_no_done", 32'(done_cnt), 0);
    check("t6_idle", 32'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
